// File: rtl/checksum_frame_tx_if.sv
// Byte-in / serial-out bundle between a payload source and checksum_frame_tx.
// The master drives bytes; the slave (the framer) drives ready and the serial strobe pair.
interface checksum_frame_tx_if;
  logic [7:0] byte_i;
  logic       valid_i;
  logic       ready_o;
  logic       data_o;
  logic       en_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output byte_i,
    output valid_i,
    input  ready_o,
    input  data_o,
    input  en_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  byte_i,
    input  valid_i,
    output ready_o,
    output data_o,
    output en_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/checksum_frame_tx.sv
// Collects NUM_BYTES bytes, appends a ones-complement checksum and shifts the frame out LSB-first.
// First frame bit appears the cycle after the last byte is accepted; ready_o is low during SHIFT and GAP.
module checksum_frame_tx #(
  parameter int NUM_BYTES  = 8,
  parameter int GAP_CYCLES = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  checksum_frame_tx_if.slave   bus
);

  localparam int FRAME_BITS = 8 * (NUM_BYTES + 1);
  localparam int BUF_BITS   = 8 * NUM_BYTES;
  localparam int BCW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int FCW        = $clog2(FRAME_BITS);
  localparam int GCW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NUM_BYTES - 1);
  localparam logic [FCW-1:0] BIT_LAST  = FCW'(FRAME_BITS - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SHIFT   = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [FCW-1:0]          bit_cnt_q,  bit_cnt_d;
  logic [GCW-1:0]          gap_cnt_q,  gap_cnt_d;
  logic [7:0]              acc_q,      acc_d;
  logic [BUF_BITS-1:0]     buf_q,      buf_d;
  logic [FRAME_BITS-1:0]   shift_q,    shift_d;
  logic                    data_q,     data_d;
  logic                    en_q,       en_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;

  logic [8:0]              sum_wide;
  logic [7:0]              acc_nxt;
  int                      slot_lsb;

  // Slot k lives at the byte position it will occupy in the frame, so the
  // buffer can be loaded into the shift register without reordering.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    shift_d    = shift_q;
    data_d     = data_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    sum_wide = {1'b0, acc_q} + {1'b0, bus.byte_i};
    acc_nxt  = sum_wide[7:0] + {7'd0, sum_wide[8]};
    slot_lsb = 8 * (NUM_BYTES - 1 - int'(byte_cnt_q));

    case (state_q)
      S_COLLECT: begin
        if (bus.valid_i) begin
          acc_d                   = acc_nxt;
          buf_d[slot_lsb +: 8]    = bus.byte_i;
          if (byte_cnt_q == BYTE_LAST) begin
            shift_d   = {~acc_nxt, buf_d};
            data_d    = bus.byte_i[0];
            en_d      = 1'b1;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          en_d   = 1'b0;
          data_d = 1'b0;
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d    = S_COLLECT;
            busy_d     = 1'b0;
            acc_d      = 8'h00;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            gap_cnt_d  = '0;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          shift_d   = shift_q >> 1;
          data_d    = shift_q[1];
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d    = S_COLLECT;
          busy_d     = 1'b0;
          acc_d      = 8'h00;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          gap_cnt_d  = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_COLLECT;
        busy_d     = 1'b0;
        en_d       = 1'b0;
        data_d     = 1'b0;
        acc_d      = 8'h00;
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
        gap_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_COLLECT;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      acc_q      <= 8'h00;
      buf_q      <= '0;
      shift_q    <= '0;
      data_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      acc_q      <= acc_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // ready is decoded from state alone so valid_i never feeds back combinationally.
  assign bus.ready_o = (state_q == S_COLLECT);
  assign bus.data_o  = data_q;
  assign bus.en_o    = en_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_checksum_frame_tx.sv
// Directed bench for checksum_frame_tx with a behavioural serial checksum checker on en_o/data_o.
module tb_checksum_frame_tx;

  localparam int NB  = 8;
  localparam int GAP = 6;
  localparam int FB  = 8 * (NB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  checksum_frame_tx_if ifc ();

  checksum_frame_tx #(.NUM_BYTES(NB), .GAP_CYCLES(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        name;
    logic [63:0]  payload;
    logic [71:0]  word;
    bit           sparse;
    bit           garbage;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [7:0] ones_sum(input logic [71:0] w);
    logic [8:0] s;
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < 9; i++) begin
      s = {1'b0, a} + {1'b0, w[8*i +: 8]};
      a = s[7:0] + {7'd0, s[8]};
    end
    return a;
  endfunction

  // Checker model: accumulates the strobed frame, can overwrite the checksum byte in flight.
  logic [71:0] cl_sr;
  int          cl_cnt;
  int          cl_frames;
  logic        cl_flag;
  logic        cl_bit;
  logic        force_cks;
  logic [7:0]  forced_val;

  always_comb begin
    cl_bit = ifc.data_o;
    if (force_cks && cl_cnt >= 64)
      cl_bit = forced_val[3'(cl_cnt - 64)];
  end

  always @(posedge clk) begin
    if (rst) begin
      cl_cnt <= 0;
    end else if (ifc.en_o) begin
      cl_sr  <= {cl_bit, cl_sr[71:1]};
      cl_cnt <= cl_cnt + 1;
    end else if (cl_cnt != 0) begin
      cl_flag   <= (cl_cnt == FB) && (ones_sum(cl_sr) == 8'hFF);
      cl_frames <= cl_frames + 1;
      cl_cnt    <= 0;
    end
  end

  initial cl_frames = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk(nm, {71'd0, act}, {71'd0, exp});
  endtask

  task automatic send_bytes(input logic [63:0] p, input int n, input bit sparse);
    int t;
    for (int k = 0; k < n; k++) begin
      if (sparse) begin
        ifc.valid_i = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      t = 0;
      while (!ifc.ready_o && t < 100) begin
        ifc.valid_i = 1'b0;
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk_b("ready_wait_timeout", 1'b0, 1'b1);
      ifc.byte_i  = p[8*(7-k) +: 8];
      ifc.valid_i = 1'b1;
      @(negedge clk);
    end
    ifc.valid_i = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [63:0] p, input bit sparse,
                           input bit garbage, input int abort_bit, output logic [71:0] w);
    logic en_ok, busy_ok, done_early, ready_seen, gap_en, gap_busy_ok;
    int   g, dones;
    send_bytes(p, NB, sparse);
    en_ok = 1'b1; busy_ok = 1'b1; done_early = 1'b0; ready_seen = 1'b0;
    w = '0;
    for (int i = 0; i < FB; i++) begin
      if (i == abort_bit) return;
      if (garbage) begin
        ifc.valid_i = 1'b1;
        ifc.byte_i  = 8'($urandom);
      end
      w[i]       = ifc.data_o;
      en_ok      = en_ok & ifc.en_o;
      busy_ok    = busy_ok & ifc.busy_o;
      done_early = done_early | ifc.done_o;
      ready_seen = ready_seen | ifc.ready_o;
      @(negedge clk);
    end
    chk_b({nm, "_en_held"}, en_ok, 1'b1);
    chk_b({nm, "_busy_shift"}, busy_ok, 1'b1);
    chk_b({nm, "_done_early"}, done_early, 1'b0);
    chk_b({nm, "_ready_in_shift"}, ready_seen, 1'b0);
    chk({nm, "_end_en_data_done"}, {69'd0, ifc.en_o, ifc.data_o, ifc.done_o}, 72'd1);
    g = 0; dones = 0; gap_en = 1'b0; gap_busy_ok = 1'b1;
    while (!ifc.ready_o && g < 50) begin
      if (garbage) begin
        ifc.valid_i = 1'b1;
        ifc.byte_i  = 8'($urandom);
      end
      dones       = dones + int'(ifc.done_o);
      gap_en      = gap_en | ifc.en_o;
      gap_busy_ok = gap_busy_ok & ifc.busy_o;
      @(negedge clk);
      g++;
    end
    ifc.valid_i = 1'b0;
    chk({nm, "_gap_len"}, 72'(g), 72'(GAP));
    chk({nm, "_done_count"}, 72'(dones), 72'd1);
    chk_b({nm, "_gap_en"}, gap_en, 1'b0);
    chk_b({nm, "_gap_busy"}, gap_busy_ok, 1'b1);
    chk_b({nm, "_idle_busy"}, ifc.busy_o, 1'b0);
  endtask

  initial begin
    logic [71:0] w;
    int          frames0;

    ifc.valid_i = 1'b0;
    ifc.byte_i  = 8'h00;
    force_cks   = 1'b0;
    forced_val  = 8'hCE;

    tbl[0] = '{"ref",      64'h60DF1E2ED0606013, 72'hCE_60DF1E2ED0606013, 1'b0, 1'b0};
    tbl[1] = '{"zeros",    64'h0000000000000000, 72'hFF_0000000000000000, 1'b0, 1'b0};
    tbl[2] = '{"ones",     64'hFFFFFFFFFFFFFFFF, 72'h00_FFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{"sparse",   64'h60DF1E2ED0606013, 72'hCE_60DF1E2ED0606013, 1'b1, 1'b0};
    tbl[4] = '{"bp_hold",  64'h60DF1E2ED0606013, 72'hCE_60DF1E2ED0606013, 1'b0, 1'b1};
    tbl[5] = '{"count",    64'h0102030405060708, 72'hDB_0102030405060708, 1'b0, 1'b1};
    tbl[6] = '{"last18",   64'h60DF1E2ED0606012, 72'hCF_60DF1E2ED0606012, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 72'({ifc.ready_o, ifc.en_o, ifc.data_o, ifc.busy_o, ifc.done_o}), 72'b10000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].name, tbl[i].payload, tbl[i].sparse, tbl[i].garbage, -1, w);
      chk({tbl[i].name, "_word"}, w, tbl[i].word);
    end

    // Closed loop: good frame passes, forced stale checksum on modified payload fails.
    frames0 = cl_frames;
    run_frame("loop_good", tbl[0].payload, 1'b0, 1'b0, -1, w);
    chk("loop_good_frames", 72'(cl_frames - frames0), 72'd1);
    chk_b("loop_good_flag", cl_flag, 1'b1);
    force_cks = 1'b1;
    frames0   = cl_frames;
    run_frame("loop_bad", tbl[6].payload, 1'b0, 1'b0, -1, w);
    chk("loop_bad_frames", 72'(cl_frames - frames0), 72'd1);
    chk_b("loop_bad_flag", cl_flag, 1'b0);
    force_cks = 1'b0;

    // Reset at SHIFT bit 30.
    run_frame("rst_shift", tbl[0].payload, 1'b0, 1'b0, 30, w);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_shift_outputs", 72'({ifc.en_o, ifc.ready_o, ifc.done_o, ifc.busy_o, ifc.data_o}), 72'b01000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_shift_after", 72'({ifc.en_o, ifc.ready_o, ifc.done_o, ifc.busy_o}), 72'b0100);
    run_frame("post_rst_shift", tbl[0].payload, 1'b0, 1'b0, -1, w);
    chk("post_rst_shift_word", w, tbl[0].word);

    // Reset after three bytes of a partial frame.
    send_bytes(64'hAABBCCDDEEFF1122, 3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame("post_rst_collect", tbl[5].payload, 1'b0, 1'b0, -1, w);
    chk("post_rst_collect_word", w, tbl[5].word);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
